// File: rtl/cache_pkg.sv
// Shared cache definitions: line-transfer FSM state encoding and default line geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } xfer_state_t;

  localparam int LINE_WORDS_DEFAULT = 4;

endpackage

// File: rtl/line_xfer_ctrl.sv
// Moves one cache line between the cache and backing memory: optional victim
// write-back, then a pipelined fill whose returning words are streamed to the cache.
module line_xfer_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_DEPTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int LW = $clog2(LINE_WORDS),
  localparam int LA = AW - LW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [LA-1:0]         req_wb_line,
  input  logic [LA-1:0]         req_fill_line,
  output logic [LW-1:0]         wb_idx,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fill_valid,
  output logic [LW-1:0]         fill_idx,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  done,
  output logic [AW-1:0]         mem_raddr,
  output logic                  mem_ren,
  input  logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic [AW-1:0]         mem_waddr,
  output logic                  mem_wen,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [LW-1:0] CNT_ONE  = LW'(1);
  localparam logic [LW-1:0] CNT_LAST = LW'(LINE_WORDS - 1);

  xfer_state_t   state_q, state_d;
  logic [LA-1:0] wb_line_q, wb_line_d;
  logic [LA-1:0] fill_line_q, fill_line_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] icnt_q, icnt_d;
  logic [LW-1:0] rcnt_q, rcnt_d;
  logic          issued_q, issued_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_line_q   <= '0;
      fill_line_q <= '0;
      wcnt_q      <= '0;
      icnt_q      <= '0;
      rcnt_q      <= '0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_line_q   <= wb_line_d;
      fill_line_q <= fill_line_d;
      wcnt_q      <= wcnt_d;
      icnt_q      <= icnt_d;
      rcnt_q      <= rcnt_d;
      issued_q    <= issued_d;
    end
  end

  // Counters wrap back to 0 on their last word, so they are already 0 when a new
  // request is accepted and stray returns outside FILL can never disturb them.
  always_comb begin
    state_d     = state_q;
    wb_line_d   = wb_line_q;
    fill_line_d = fill_line_q;
    wcnt_d      = wcnt_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    issued_d    = issued_q;
    req_ready   = 1'b0;
    wb_idx      = '0;
    fill_valid  = 1'b0;
    fill_idx    = '0;
    fill_data   = '0;
    done        = 1'b0;
    mem_raddr   = '0;
    mem_ren     = 1'b0;
    mem_waddr   = '0;
    mem_wen     = 1'b0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wb_line_d   = req_wb_line;
          fill_line_d = req_fill_line;
          issued_d    = 1'b0;
          state_d     = req_wb ? WB : FILL;
        end
      end

      WB: begin
        mem_wen   = 1'b1;
        mem_waddr = {wb_line_q, wcnt_q};
        wb_idx    = wcnt_q;
        mem_wdata = wb_data;
        if (mem_wready) begin
          wcnt_d = wcnt_q + CNT_ONE;
          if (wcnt_q == CNT_LAST) state_d = FILL;
        end
      end

      // Reads issue back to back while earlier words are still returning.
      FILL: begin
        if (!issued_q) begin
          mem_ren   = 1'b1;
          mem_raddr = {fill_line_q, icnt_q};
          if (mem_rready) begin
            icnt_d = icnt_q + CNT_ONE;
            if (icnt_q == CNT_LAST) issued_d = 1'b1;
          end
        end
        if (mem_rdata_valid) begin
          fill_valid = 1'b1;
          fill_idx   = rcnt_q;
          fill_data  = mem_rdata;
          rcnt_d     = rcnt_q + CNT_ONE;
          if (rcnt_q == CNT_LAST) state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Scoreboard bench for line_xfer_ctrl: a behavioural memory answers reads one cycle
// after acceptance, expected writes/reads/fill words are queued per request.
module tb_line_xfer_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LW = 2;
  localparam int LA = 3;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_wb;
  logic [LA-1:0] req_wb_line, req_fill_line;
  logic [LW-1:0] wb_idx;
  logic [DW-1:0] wb_data;
  logic          fill_valid;
  logic [LW-1:0] fill_idx;
  logic [DW-1:0] fill_data;
  logic          done;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_ren, mem_rready, mem_rdata_valid, mem_wen, mem_wready;
  logic [DW-1:0] mem_rdata, mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_model [32];
  logic [AW-1:0] exp_waddr [$];
  logic [DW-1:0] exp_wdata [$];
  logic [AW-1:0] exp_raddr [$];
  logic [LW-1:0] exp_fidx  [$];
  logic [DW-1:0] exp_fdata [$];
  logic          pend;
  logic [DW-1:0] pend_data;

  line_xfer_ctrl #(.MEM_DEPTH(32), .DATA_WIDTH(DW), .LINE_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_wb_line(req_wb_line), .req_fill_line(req_fill_line),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe-gated outputs must read as zero whenever their strobe is low.
  task automatic check_idle_zeros();
    if (!mem_ren) check_output("raddr_zero", 32'(mem_raddr), 0);
    if (!mem_wen) begin
      check_output("waddr_zero", 32'(mem_waddr), 0);
      check_output("wdata_zero", mem_wdata, 0);
    end
    if (!fill_valid) check_output("fdata_zero", fill_data, 0);
  endtask

  task automatic run_xfer(input bit do_wb, input int wbl, input int fl,
                          input logic [31:0] rready_lo, input logic [31:0] wready_lo,
                          input int exp_done, input bit hold_req, input int reset_at);
    bit fin = 1'b0;
    bit aborted = 1'b0;
    if (do_wb)
      for (int w = 0; w < NW; w++) begin
        exp_waddr.push_back(AW'(wbl * NW + w));
        exp_wdata.push_back(32'hB0 + w);
      end
    for (int w = 0; w < NW; w++) begin
      exp_raddr.push_back(AW'(fl * NW + w));
      exp_fidx.push_back(LW'(w));
      exp_fdata.push_back(mem_model[fl * NW + w]);
    end
    @(negedge clk);
    req_valid = 1'b1; req_wb = do_wb;
    req_wb_line = LA'(wbl); req_fill_line = LA'(fl);
    mem_rdata_valid = 1'b0; mem_rdata = '0;
    #1;
    check_output("accept_ready", 32'(req_ready), 1);
    for (int c = 1; c <= 40 && !fin; c++) begin
      @(negedge clk);
      mem_rdata_valid = pend; mem_rdata = pend ? pend_data : '0; pend = 1'b0;
      mem_rready = !rready_lo[c]; mem_wready = !wready_lo[c];
      req_valid = hold_req;
      #1; wb_data = 32'hB0 + 32'(wb_idx); #1;
      if (c == reset_at) begin
        rst_n = 1'b0; #1;
        check_output("rst_ren", 32'(mem_ren), 0);
        check_output("rst_wen", 32'(mem_wen), 0);
        check_output("rst_fill_valid", 32'(fill_valid), 0);
        check_output("rst_done", 32'(done), 0);
        check_idle_zeros();
        exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete();
        exp_fidx.delete(); exp_fdata.delete();
        mem_rdata_valid = 1'b0; req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        check_output("rst_release_ready", 32'(req_ready), 1);
        fin = 1'b1; aborted = 1'b1;
      end else begin
        check_output("busy_ready", 32'(req_ready), 0);
        check_output("ren_wen_excl", 32'(mem_ren & mem_wen), 0);
        check_output("fill_follows_rvalid", 32'(fill_valid), 32'(mem_rdata_valid));
        check_idle_zeros();
        if (mem_wen) begin
          if (exp_waddr.size() == 0) check_output("extra_write", 1, 0);
          else begin
            check_output("waddr", 32'(mem_waddr), 32'(exp_waddr[0]));
            check_output("wdata", mem_wdata, exp_wdata[0]);
            if (mem_wready) begin
              mem_model[mem_waddr] = mem_wdata;
              void'(exp_waddr.pop_front()); void'(exp_wdata.pop_front());
            end
          end
        end
        if (mem_ren) begin
          if (exp_raddr.size() == 0) check_output("extra_read", 1, 0);
          else begin
            check_output("raddr", 32'(mem_raddr), 32'(exp_raddr[0]));
            if (mem_rready) begin
              pend = 1'b1; pend_data = mem_model[mem_raddr];
              void'(exp_raddr.pop_front());
            end
          end
        end
        if (fill_valid) begin
          if (exp_fidx.size() == 0) check_output("extra_fill", 1, 0);
          else begin
            check_output("fill_idx", 32'(fill_idx), 32'(exp_fidx.pop_front()));
            check_output("fill_data", fill_data, exp_fdata.pop_front());
          end
        end
        if (done) begin
          check_output("done_cycle", 32'(c), 32'(exp_done));
          req_valid = 1'b0;
          fin = 1'b1;
        end
      end
    end
    if (!fin) check_output("timeout", 1, 0);
    if (!aborted) begin
      @(negedge clk);
      mem_rdata_valid = 1'b0; #1;
      check_output("post_done_ready", 32'(req_ready), 1);
      check_output("post_done_pulse", 32'(done), 0);
      check_output("queues_empty", 32'(exp_waddr.size() + exp_raddr.size() + exp_fidx.size()), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 32'hA000_0000 | i;
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_wb_line = '0; req_fill_line = '0;
    wb_data = '0; mem_rready = 1'b1; mem_wready = 1'b1; mem_rdata = '0; mem_rdata_valid = 1'b0;
    pend = 1'b0; pend_data = '0;
    #1;
    check_output("reset_ren", 32'(mem_ren), 0);
    check_output("reset_wen", 32'(mem_wen), 0);
    check_output("reset_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    check_output("reset_ready", 32'(req_ready), 1);

    // Fill only, line 2, memory always ready
    run_xfer(1'b0, 0, 2, 32'h0, 32'h0, 6, 1'b0, 0);
    // Write back line 1 then fill line 3
    run_xfer(1'b1, 1, 3, 32'h0, 32'h0, 10, 1'b0, 0);
    // Read port stalls in cycles 2-3
    run_xfer(1'b0, 0, 2, 32'hC, 32'h0, 8, 1'b0, 0);
    // Write port stalls once on word 2
    run_xfer(1'b1, 1, 3, 32'h0, 32'h8, 11, 1'b0, 0);
    // Reset in the middle of a fill, then a clean transfer from word 0
    run_xfer(1'b0, 0, 2, 32'h0, 32'h0, 6, 1'b0, 4);
    run_xfer(1'b0, 0, 5, 32'h0, 32'h0, 6, 1'b0, 0);

    // Stray read returns while idle must not reach the cache
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD_0000 | k; #1;
      check_output("idle_spurious_fill", 32'(fill_valid), 0);
      check_output("idle_ready", 32'(req_ready), 1);
    end
    // Request held high through a whole fill is not re-accepted until idle
    run_xfer(1'b0, 0, 2, 32'h0, 32'h0, 6, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
